// File: rtl/el2_mem_init.sv
// DCCM initialization sequencer: zero-fills every bank word with matching check bits, then passes core traffic through.
// Optional read-back verify pass is built when EL2_MEM_INIT_VERIFY_EN is defined.
module el2_mem_init #(
  parameter int unsigned NUM_BANKS  = 4,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DEPTH      = 4096,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ECC_WIDTH  = 7,
  parameter logic [ECC_WIDTH-1:0] ZERO_ECC = 7'h00
) (
  input  logic                            clk,
  input  logic                            rst_l,
  input  logic                            init_req,
  output logic                            init_done,
  output logic                            core_stall,
  input  logic [NUM_BANKS-1:0]            core_clken,
  input  logic [NUM_BANKS-1:0]            core_wren_bank,
  input  logic [NUM_BANKS*ADDR_WIDTH-1:0] core_addr_bank,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0] core_wr_data_bank,
  input  logic [NUM_BANKS*ECC_WIDTH-1:0]  core_wr_ecc_bank,
  output logic [NUM_BANKS*DATA_WIDTH-1:0] core_bank_dout,
  output logic [NUM_BANKS*ECC_WIDTH-1:0]  core_bank_ecc,
  output logic [NUM_BANKS-1:0]            mem_clken,
  output logic [NUM_BANKS-1:0]            mem_wren_bank,
  output logic [NUM_BANKS*ADDR_WIDTH-1:0] mem_addr_bank,
  output logic [NUM_BANKS*DATA_WIDTH-1:0] mem_wr_data_bank,
  output logic [NUM_BANKS*ECC_WIDTH-1:0]  mem_wr_ecc_bank,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0] mem_bank_dout,
  input  logic [NUM_BANKS*ECC_WIDTH-1:0]  mem_bank_ecc,
  output logic                            init_err
);

  localparam int unsigned CNT_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    INIT_WR = 2'd1,
    VERIFY  = 2'd2,
    DONE    = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] cnt_addr;

  assign cnt_addr = ADDR_WIDTH'(cnt_q);

`ifdef EL2_MEM_INIT_VERIFY_EN
  // tail_q marks the trailing compare-only cycle; cmp_vld_q means last cycle issued a read
  logic tail_q, tail_d;
  logic cmp_vld_q, cmp_vld_d;
  logic err_q, err_d;
  logic rd_bad;

  assign rd_bad = (|mem_bank_dout) || (mem_bank_ecc != {NUM_BANKS{ZERO_ECC}});
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
`ifdef EL2_MEM_INIT_VERIFY_EN
    tail_d    = tail_q;
    cmp_vld_d = (state_q == VERIFY) && !tail_q;
    err_d     = err_q;
    if (cmp_vld_q && rd_bad) err_d = 1'b1;
`endif
    case (state_q)
      IDLE: begin
        state_d = INIT_WR;
        cnt_d   = '0;
      end
      INIT_WR: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
`ifdef EL2_MEM_INIT_VERIFY_EN
          state_d = VERIFY;
          tail_d  = 1'b0;
`else
          state_d = DONE;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef EL2_MEM_INIT_VERIFY_EN
      VERIFY: begin
        if (tail_q) begin
          state_d = DONE;
          tail_d  = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d  = '0;
          tail_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      DONE: begin
        if (init_req) begin
          state_d = INIT_WR;
          cnt_d   = '0;
`ifdef EL2_MEM_INIT_VERIFY_EN
          err_d   = 1'b0;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q <= IDLE;
      cnt_q   <= '0;
`ifdef EL2_MEM_INIT_VERIFY_EN
      tail_q    <= 1'b0;
      cmp_vld_q <= 1'b0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
`ifdef EL2_MEM_INIT_VERIFY_EN
      tail_q    <= tail_d;
      cmp_vld_q <= cmp_vld_d;
      err_q     <= err_d;
`endif
    end
  end

`ifdef EL2_MEM_INIT_VERIFY_EN
  assign init_err = err_q;
`else
  assign init_err = 1'b0;
`endif

  assign init_done  = (state_q == DONE);
  assign core_stall = ~init_done;

  // Bank-port ownership: sequencer drives the macros everywhere except DONE
  always_comb begin
    mem_clken        = '0;
    mem_wren_bank    = '0;
    mem_addr_bank    = '0;
    mem_wr_data_bank = '0;
    mem_wr_ecc_bank  = '0;
    core_bank_dout   = '0;
    core_bank_ecc    = '0;
    case (state_q)
      INIT_WR: begin
        mem_clken       = {NUM_BANKS{1'b1}};
        mem_wren_bank   = {NUM_BANKS{1'b1}};
        mem_addr_bank   = {NUM_BANKS{cnt_addr}};
        mem_wr_ecc_bank = {NUM_BANKS{ZERO_ECC}};
      end
`ifdef EL2_MEM_INIT_VERIFY_EN
      VERIFY: begin
        if (!tail_q) begin
          mem_clken     = {NUM_BANKS{1'b1}};
          mem_addr_bank = {NUM_BANKS{cnt_addr}};
        end
      end
`endif
      DONE: begin
        mem_clken        = core_clken;
        mem_wren_bank    = core_wren_bank;
        mem_addr_bank    = core_addr_bank;
        mem_wr_data_bank = core_wr_data_bank;
        mem_wr_ecc_bank  = core_wr_ecc_bank;
        core_bank_dout   = mem_bank_dout;
        core_bank_ecc    = mem_bank_ecc;
      end
      default: begin
        mem_clken = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_el2_mem_init.sv
// Directed-plus-random bench for el2_mem_init with a behavioural bank-macro model.
module tb_el2_mem_init;
  localparam int NB = 4, AW = 12, DEPTH = 16, DW = 32, EW = 7;
  localparam logic [EW-1:0] ZECC = 7'h2B;

  logic clk = 1'b0;
  logic rst_l = 1'b0;
  logic init_req = 1'b0;
  logic init_done, core_stall, init_err;
  logic [NB-1:0]    core_clken = '0, core_wren_bank = '0;
  logic [NB*AW-1:0] core_addr_bank = '0;
  logic [NB*DW-1:0] core_wr_data_bank = '0;
  logic [NB*EW-1:0] core_wr_ecc_bank = '0;
  logic [NB*DW-1:0] core_bank_dout;
  logic [NB*EW-1:0] core_bank_ecc;
  logic [NB-1:0]    mem_clken, mem_wren_bank;
  logic [NB*AW-1:0] mem_addr_bank;
  logic [NB*DW-1:0] mem_wr_data_bank;
  logic [NB*EW-1:0] mem_wr_ecc_bank;
  logic [NB*DW-1:0] mem_bank_dout;
  logic [NB*EW-1:0] mem_bank_ecc;

  int n_cmp = 0;
  int n_err = 0;
  bit req_noise = 1'b0;
  bit inj = 1'b0;

  always #5 clk = ~clk;

  el2_mem_init #(.NUM_BANKS(NB), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .DATA_WIDTH(DW),
                 .ECC_WIDTH(EW), .ZERO_ECC(ZECC)) dut (
    .clk(clk), .rst_l(rst_l), .init_req(init_req), .init_done(init_done),
    .core_stall(core_stall), .core_clken(core_clken), .core_wren_bank(core_wren_bank),
    .core_addr_bank(core_addr_bank), .core_wr_data_bank(core_wr_data_bank),
    .core_wr_ecc_bank(core_wr_ecc_bank), .core_bank_dout(core_bank_dout),
    .core_bank_ecc(core_bank_ecc), .mem_clken(mem_clken), .mem_wren_bank(mem_wren_bank),
    .mem_addr_bank(mem_addr_bank), .mem_wr_data_bank(mem_wr_data_bank),
    .mem_wr_ecc_bank(mem_wr_ecc_bank), .mem_bank_dout(mem_bank_dout),
    .mem_bank_ecc(mem_bank_ecc), .init_err(init_err));

  // Bank macro model: 1-cycle read latency, optional fault on bank 1 word 9
  logic [DW-1:0] mdat [NB][DEPTH];
  logic [EW-1:0] mecc [NB][DEPTH];
  logic [DW-1:0] dout_q [NB];
  logic [EW-1:0] eccq [NB];
  int midx;

  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (mem_clken[b]) begin
        midx = int'(mem_addr_bank[b*AW +: AW]) % DEPTH;
        if (mem_wren_bank[b]) begin
          mdat[b][midx] <= mem_wr_data_bank[b*DW +: DW];
          mecc[b][midx] <= mem_wr_ecc_bank[b*EW +: EW];
        end else begin
          dout_q[b] <= (inj && b == 1 && midx == 9) ? 32'h1 : mdat[b][midx];
          eccq[b]   <= mecc[b][midx];
        end
      end
    end
  end

  for (genvar g = 0; g < NB; g++) begin : g_dout
    assign mem_bank_dout[g*DW +: DW] = dout_q[g];
    assign mem_bank_ecc[g*EW +: EW]  = eccq[g];
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rand_core();
    core_clken     = NB'($urandom);
    core_wren_bank = NB'($urandom);
    for (int b = 0; b < NB; b++) begin
      core_addr_bank[b*AW +: AW]    = AW'($urandom);
      core_wr_data_bank[b*DW +: DW] = $urandom;
      core_wr_ecc_bank[b*EW +: EW]  = EW'($urandom);
    end
    init_req = req_noise ? ($urandom_range(0, 3) == 0) : 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    rand_core();
    #2;
  endtask

  task automatic chk_idle();
    chk("idle_en", 256'({mem_clken, mem_wren_bank}), 256'(0));
    chk("idle_dout", 256'({core_bank_dout, core_bank_ecc}), 256'(0));
    chk("idle_status", 256'({init_done, core_stall, init_err}), 256'(3'b010));
  endtask

  task automatic chk_init(input int k);
    logic [NB*AW-1:0] ea;
    for (int b = 0; b < NB; b++) ea[b*AW +: AW] = AW'(k);
    chk($sformatf("init_en_%0d", k), 256'({mem_clken, mem_wren_bank}), 256'({2*NB{1'b1}}));
    chk($sformatf("init_addr_%0d", k), 256'(mem_addr_bank), 256'(ea));
    chk("init_data", 256'(mem_wr_data_bank), 256'(0));
    chk("init_ecc", 256'(mem_wr_ecc_bank), 256'({NB{ZECC}}));
    chk("init_core_rd", 256'({core_bank_dout, core_bank_ecc}), 256'(0));
    chk("init_status", 256'({init_done, core_stall, init_err}), 256'(3'b010));
  endtask

  task automatic chk_ver(input int k);
    logic [NB*AW-1:0] ea;
    for (int b = 0; b < NB; b++) ea[b*AW +: AW] = AW'(k);
    chk($sformatf("ver_en_%0d", k), 256'({mem_clken, mem_wren_bank}), 256'({{NB{1'b1}}, {NB{1'b0}}}));
    chk($sformatf("ver_addr_%0d", k), 256'(mem_addr_bank), 256'(ea));
    chk("ver_status", 256'({init_done, core_stall}), 256'(2'b01));
  endtask

  task automatic chk_done(input logic exp_err);
    chk("done_clken", 256'(mem_clken), 256'(core_clken));
    chk("done_wren", 256'(mem_wren_bank), 256'(core_wren_bank));
    chk("done_addr", 256'(mem_addr_bank), 256'(core_addr_bank));
    chk("done_data", 256'(mem_wr_data_bank), 256'(core_wr_data_bank));
    chk("done_ecc", 256'(mem_wr_ecc_bank), 256'(core_wr_ecc_bank));
    chk("done_dout", 256'({core_bank_dout, core_bank_ecc}), 256'({mem_bank_dout, mem_bank_ecc}));
    chk("done_status", 256'({init_done, core_stall, init_err}), 256'({2'b10, exp_err}));
  endtask

  // One complete initialization: DEPTH writes, optional verify, then DONE
  task automatic expect_pass(input logic exp_err);
    req_noise = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      chk_init(k);
`ifndef EL2_MEM_INIT_VERIFY_EN
      if (k == DEPTH - 1) req_noise = 1'b0;
`endif
      tick();
    end
`ifdef EL2_MEM_INIT_VERIFY_EN
    for (int k = 0; k < DEPTH; k++) begin
      chk_ver(k);
      tick();
    end
    chk("tail_en", 256'({mem_clken, mem_wren_bank}), 256'(0));
    chk("tail_status", 256'({init_done, core_stall}), 256'(2'b01));
    req_noise = 1'b0;
    tick();
`endif
    chk_done(exp_err);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rand_core();
    repeat (2) begin tick(); chk_idle(); end
    @(posedge clk); #1; rst_l = 1'b1; rand_core(); #2;
    chk_idle();
    tick();
    expect_pass(1'b0);

    repeat (10) begin tick(); chk_done(1'b0); end

    tick();
    core_clken = 4'b0100; core_wren_bank = 4'b0100;
    core_addr_bank[2*AW +: AW] = AW'(5); core_wr_data_bank[2*DW +: DW] = 32'hDEADBEEF;
    #1;
    chk_done(1'b0);
    chk("wr_mirror_b2", 256'(mem_wr_data_bank[2*DW +: DW]), 256'(32'hDEADBEEF));
    tick();
    core_clken = 4'b0100; core_wren_bank = 4'b0000; core_addr_bank[2*AW +: AW] = AW'(5);
    #1;
    chk_done(1'b0);
    tick();
    chk_done(1'b0);
    chk("rd_b2", 256'(core_bank_dout[2*DW +: DW]), 256'(32'hDEADBEEF));

    tick();
    core_clken = 4'b0001; core_wren_bank = 4'b0001; core_addr_bank[AW-1:0] = AW'(3);
    init_req = 1'b1;
    #1;
    chk_done(1'b0);
    chk("req_wr_addr", 256'(mem_addr_bank[AW-1:0]), 256'(AW'(3)));
    tick();
    expect_pass(1'b0);

    tick();
    init_req = 1'b1;
    #1;
    chk_done(1'b0);
    tick();
    for (int k = 0; k < 8; k++) begin
      chk_init(k);
      if (k < 7) tick();
    end
    rst_l = 1'b0;
    #1;
    chk_idle();
    tick(); chk_idle();
    @(posedge clk); #1; rst_l = 1'b1; rand_core(); #2;
    chk_idle();
    tick();
    expect_pass(1'b0);

`ifdef EL2_MEM_INIT_VERIFY_EN
    inj = 1'b1;
    tick();
    init_req = 1'b1;
    #1;
    chk_done(1'b0);
    tick();
    expect_pass(1'b1);
    inj = 1'b0;
    tick();
    chk_done(1'b1);
    init_req = 1'b1;
    #1;
    tick();
    expect_pass(1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
